dbus_responder: RTL and testbench

Data-bus responder sitting on the CPU's data-memory port. It decodes each CPU load/store address and steers it either to the 64 KiB data RAM or to a memory-mapped peripheral page. The peripheral page holds switches, LEDs, an 8-digit seven-segment display with its own scan logic, and an optional free-running timer. Loads return read data combinationally within the same single-cycle instruction; stores commit on the rising clock edge.

---
 rtl/dbus_responder.sv | 195 +++++++++++++++++++
 tb/tb_dbus_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// Data-bus responder: steers CPU loads/stores to the data RAM or to the
// peripheral page at 0xFFFF_F000 (display, LEDs, switches, optional timer).
// Define DBUS_TIMER_EN to build the free-running TIMER register at offset 0x020.
module dbus_responder #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned TIMER_DIV = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic [13:0] ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic [23:0] sw,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam logic [11:0] OffDisp  = 12'h000;
  localparam logic [11:0] OffTimer = 12'h020;
  localparam logic [11:0] OffLed   = 12'h060;
  localparam logic [11:0] OffSw    = 12'h070;

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Region decode and RAM pass-through
  logic        periph_hit;
  logic [11:0] off;
  logic        wr_en;
  logic        wr_disp;
  logic        wr_led;
  logic        wr_timer;

  assign periph_hit = (cpu_addr[31:12] == 20'hFFFFF);
  assign off        = cpu_addr[11:0];
  assign wr_en      = cpu_we & periph_hit;
  assign wr_disp    = wr_en & (off == OffDisp);
  assign wr_led     = wr_en & (off == OffLed);
  assign wr_timer   = wr_en & (off == OffTimer);

  // RAM write is deliberately not gated by rst; the RAM has no reset.
  assign ram_addr  = cpu_addr[15:2];
  assign ram_we    = cpu_we & ~periph_hit;
  assign ram_wdata = cpu_wdata;

  // Peripheral state
  logic [31:0]      disp_q;
  logic [23:0]      led_q;
  logic [23:0]      sw_meta_q;
  logic [23:0]      sw_sync_q;
  logic [ScanW-1:0] scan_cnt_q;
  logic [ScanW-1:0] scan_cnt_d;
  logic [2:0]       dsel_q;
  logic [2:0]       dsel_d;
  logic [7:0]       dig_en_q;
  logic [7:0]       dig_en_d;
  logic [7:0]       dig_seg_q;
  logic [7:0]       dig_seg_d;
  logic [3:0]       nibble;
  logic [31:0]      timer_rd;
  logic [31:0]      periph_rdata;

  // Register writes for DISP and LED; rst overrides a coincident store
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      led_q  <= '0;
    end else begin
      if (wr_disp) disp_q <= cpu_wdata;
      if (wr_led)  led_q  <= cpu_wdata[23:0];
    end
  end

  // Two-flop synchronizer for the asynchronous switches
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Scan counter and digit-select next state
  always_comb begin
    scan_cnt_d = scan_cnt_q + ScanW'(1);
    dsel_d     = dsel_q;
    if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dsel_d     = dsel_q + 3'd1;
    end
  end

  // Digit outputs derive from the current dsel/DISP, so they lag by one cycle
  always_comb begin
    nibble   = disp_q[{dsel_q, 2'b00} +: 4];
    dig_en_d = ~(8'b1 << dsel_q);
    case (nibble)
      4'h0:    dig_seg_d = 8'hC0;
      4'h1:    dig_seg_d = 8'hF9;
      4'h2:    dig_seg_d = 8'hA4;
      4'h3:    dig_seg_d = 8'hB0;
      4'h4:    dig_seg_d = 8'h99;
      4'h5:    dig_seg_d = 8'h92;
      4'h6:    dig_seg_d = 8'h82;
      4'h7:    dig_seg_d = 8'hF8;
      4'h8:    dig_seg_d = 8'h80;
      4'h9:    dig_seg_d = 8'h90;
      4'hA:    dig_seg_d = 8'h88;
      4'hB:    dig_seg_d = 8'h83;
      4'hC:    dig_seg_d = 8'hC6;
      4'hD:    dig_seg_d = 8'hA1;
      4'hE:    dig_seg_d = 8'h86;
      default: dig_seg_d = 8'h8E;
    endcase
  end

  // Display scan state and registered digit drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      dsel_q     <= '0;
      dig_en_q   <= 8'hFE;
      dig_seg_q  <= 8'hC0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dsel_q     <= dsel_d;
      dig_en_q   <= dig_en_d;
      dig_seg_q  <= dig_seg_d;
    end
  end

`ifdef DBUS_TIMER_EN
  localparam int unsigned PreW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PreW-1:0] pre_q;
  logic [PreW-1:0] pre_d;
  logic [31:0]     timer_q;
  logic [31:0]     timer_d;
  logic            tick;

  assign tick = (pre_q == PreW'(TIMER_DIV - 1));

  // Prescaler/timer next state; a store beats a coincident tick
  always_comb begin
    pre_d   = tick ? '0 : pre_q + PreW'(1);
    timer_d = tick ? timer_q + 32'd1 : timer_q;
    if (wr_timer) begin
      pre_d   = '0;
      timer_d = cpu_wdata;
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      timer_q <= '0;
    end else begin
      pre_q   <= pre_d;
      timer_q <= timer_d;
    end
  end

  assign timer_rd = timer_q;
`else
  logic unused_timer;
  assign unused_timer = wr_timer ^ (^TIMER_DIV);
  assign timer_rd     = '0;
`endif

  // Peripheral read mux; unmapped or unaligned offsets read as zero
  always_comb begin
    periph_rdata = '0;
    case (off)
      OffDisp:  periph_rdata = disp_q;
      OffTimer: periph_rdata = timer_rd;
      OffLed:   periph_rdata = {8'h00, led_q};
      OffSw:    periph_rdata = {8'h00, sw_sync_q};
      default:  periph_rdata = '0;
    endcase
  end

  assign cpu_rdata = periph_hit ? periph_rdata : ram_rdata;
  assign led       = led_q;
  assign dig_en    = dig_en_q;
  assign dig_seg   = dig_seg_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed self-checking bench for dbus_responder (SCAN_DIV=4, TIMER_DIV=3).
module tb_dbus_responder;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int n_vec = 0;
  int n_err = 0;

  dbus_responder #(
    .SCAN_DIV (4),
    .TIMER_DIV(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_we   (cpu_we),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .sw       (sw),
    .led      (led),
    .dig_en   (dig_en),
    .dig_seg  (dig_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    cpu_we   = 1'b0;
    cpu_addr = addr;
    #1;
    chk(tag, cpu_rdata, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_we    = 1'b1;
    tick();
    cpu_we    = 1'b0;
  endtask

  initial begin
    int k;
    logic [7:0] exp_en;
    logic [7:0] exp_seg;

    rst       = 1'b1;
    cpu_addr  = '0;
    cpu_we    = 1'b0;
    cpu_wdata = '0;
    ram_rdata = '0;
    sw        = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_led", {8'h0, led}, 32'h0);
    chk("rst_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("rst_dig_seg", {24'h0, dig_seg}, 32'hC0);
    rd("rst_disp", 32'hFFFF_F000, 32'h0);

    // Display scan: 0xA3 -> digit0 '3', digit1 'A', rest '0'
    wr(32'hFFFF_F000, 32'h0000_00A3);
    chk("disp_e1_en", {24'h0, dig_en}, 32'hFE);
    chk("disp_e1_seg", {24'h0, dig_seg}, 32'hC0);
    for (int n = 2; n <= 36; n++) begin
      tick();
      k       = ((n - 1) / 4) % 8;
      exp_en  = ~(8'b1 << k);
      exp_seg = (k == 0) ? 8'hB0 : (k == 1) ? 8'h88 : 8'hC0;
      chk($sformatf("disp_e%0d_en", n), {24'h0, dig_en}, {24'h0, exp_en});
      chk($sformatf("disp_e%0d_seg", n), {24'h0, dig_seg}, {24'h0, exp_seg});
    end

    // RAM pass-through
    cpu_addr  = 32'h0000_0104;
    cpu_wdata = 32'h1234_5678;
    cpu_we    = 1'b1;
    ram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ram_we_hit", {31'h0, ram_we}, 32'h1);
    chk("ram_addr", {18'h0, ram_addr}, 32'h041);
    chk("ram_wdata", ram_wdata, 32'h1234_5678);
    chk("ram_rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick();
    cpu_addr = 32'hFFFF_F104;
    #1;
    chk("ram_we_periph", {31'h0, ram_we}, 32'h0);
    tick();
    rd("unmapped_rd", 32'hFFFF_F104, 32'h0);

    // LED
    cpu_addr  = 32'hFFFF_F060;
    cpu_wdata = 32'hAB00_00FF;
    cpu_we    = 1'b1;
    #1;
    chk("led_ram_we", {31'h0, ram_we}, 32'h0);
    tick();
    cpu_we = 1'b0;
    chk("led_out", {8'h0, led}, 32'h0000_00FF);
    rd("led_rd", 32'hFFFF_F060, 32'h0000_00FF);
    rd("unaligned_rd", 32'hFFFF_F061, 32'h0);

    // SW is read-only
    wr(32'hFFFF_F070, 32'hFFFF_FFFF);
    rd("sw_ro", 32'hFFFF_F070, 32'h0);

    // Switch synchronizer: visible after two edges
    sw = 24'h5A5A5A;
    rd("sw_e0", 32'hFFFF_F070, 32'h0);
    tick();
    rd("sw_e1", 32'hFFFF_F070, 32'h0);
    tick();
    rd("sw_e2", 32'hFFFF_F070, 32'h005A_5A5A);

`ifdef DBUS_TIMER_EN
    wr(32'hFFFF_F020, 32'hFFFF_FFFE);
    rd("tmr_load", 32'hFFFF_F020, 32'hFFFF_FFFE);
    tick();
    rd("tmr_s1", 32'hFFFF_F020, 32'hFFFF_FFFE);
    tick();
    tick();
    rd("tmr_s3", 32'hFFFF_F020, 32'hFFFF_FFFF);
    tick();
    tick();
    tick();
    rd("tmr_wrap", 32'hFFFF_F020, 32'h0);
    tick();
    tick();
    wr(32'hFFFF_F020, 32'h0000_0005);
    rd("tmr_st_tick", 32'hFFFF_F020, 32'h5);
    tick();
    tick();
    rd("tmr_hold", 32'hFFFF_F020, 32'h5);
    tick();
    rd("tmr_inc", 32'hFFFF_F020, 32'h6);
`else
    wr(32'hFFFF_F020, 32'h1234_5678);
    rd("tmr_absent", 32'hFFFF_F020, 32'h0);
`endif

    // DISP readback, then reset with a pending LED store
    wr(32'hFFFF_F000, 32'h89AB_CDEF);
    rd("disp_rd", 32'hFFFF_F000, 32'h89AB_CDEF);
    rst       = 1'b1;
    cpu_addr  = 32'hFFFF_F060;
    cpu_wdata = 32'h0012_3456;
    cpu_we    = 1'b1;
    tick();
    cpu_we = 1'b0;
    rst    = 1'b0;
    chk("rst2_led", {8'h0, led}, 32'h0);
    chk("rst2_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("rst2_dig_seg", {24'h0, dig_seg}, 32'hC0);
    rd("rst2_disp", 32'hFFFF_F000, 32'h0);
    rd("rst2_led_rd", 32'hFFFF_F060, 32'h0);

    // ram_we ignores rst
    rst       = 1'b1;
    cpu_addr  = 32'h0000_0200;
    cpu_we    = 1'b1;
    #1;
    chk("rst_ram_we", {31'h0, ram_we}, 32'h1);
    tick();
    rst    = 1'b0;
    cpu_we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
